memory_mb_arb: RTL and testbench

- Single-clock, multi-bank memory shared by num_ports requestors over one flat, bank-interleaved address space.
- Each bank accepts one write and one read per cycle; conflicting requests are resolved by per-bank round-robin arbitration with a valid/ready handshake.
- Read data returns with fixed 1-cycle latency.
- Successor to the fixed per-bank-addressed multi-bank dual-port memory; used wherever several engines share one scratchpad.

---
 rtl/memory_mb_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 42 ++++
 rtl/memory_mb_arb.sv | 118 +++++++++++
 tb/tb_memory_mb_arb.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_mb_pkg.sv
// Shared address-map helpers for the banked scratchpad: a flat word address is
// split into a low-order bank select and the remaining upper entry bits.
package memory_mb_pkg;

    localparam int default_num_banks        = 4;
    localparam int default_num_bank_entries = 8;
    localparam int bank_sel_width           = $clog2(default_num_banks);
    localparam int entry_width              = $clog2(default_num_bank_entries);
    localparam int flat_addr_width          = bank_sel_width + entry_width;

    typedef logic [bank_sel_width-1:0]  bank_t;
    typedef logic [entry_width-1:0]     entry_t;
    typedef logic [flat_addr_width-1:0] addr_t;

    // Low bits pick the bank so consecutive words land in consecutive banks
    function automatic bank_t bank_of(input addr_t addr);
        return addr[bank_sel_width-1:0];
    endfunction

    function automatic entry_t entry_of(input addr_t addr);
        return addr[flat_addr_width-1:bank_sel_width];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts at the pointer and wraps; after a grant
// the pointer moves to the port just past the winner.
module rr_arbiter #(
    parameter int num_req = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [num_req-1:0] req,
    output logic [num_req-1:0] grant
);

    localparam int ptr_width = (num_req > 1) ? $clog2(num_req) : 1;

    logic [ptr_width-1:0] ptr;
    logic [ptr_width-1:0] ptr_next;
    logic                 found;
    int                   idx;

    always_comb begin
        grant    = '0;
        ptr_next = ptr;
        found    = 1'b0;
        idx      = 0;
        for (int i = 0; i < num_req; i++) begin
            idx = (int'(ptr) + i) % num_req;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
                ptr_next   = ptr_width'((idx + 1) % num_req);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_next;
        end
    end

endmodule

// File: rtl/memory_mb_arb.sv
// Banked scratchpad shared by several requestors: every bank has its own read and
// write round-robin arbiter, writes land at the edge, reads return one cycle later.
module memory_mb_arb
    import memory_mb_pkg::*;
#(
    parameter int bit_width        = 32,
    parameter int num_banks        = default_num_banks,
    parameter int num_bank_entries = default_num_bank_entries,
    parameter int num_ports        = 2,
    parameter int addr_bit_width   = $clog2(num_banks * num_bank_entries)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [num_ports-1:0]      req_valid,
    input  logic [num_ports-1:0]      req_we,
    input  logic [addr_bit_width-1:0] req_addr  [num_ports],
    input  logic [bit_width-1:0]      req_wdata [num_ports],
    output logic [num_ports-1:0]      req_ready,
    output logic [num_ports-1:0]      rsp_valid,
    output logic [bit_width-1:0]      rsp_rdata [num_ports]
);

    logic [num_ports-1:0] wr_req [num_banks];
    logic [num_ports-1:0] rd_req [num_banks];
    logic [num_ports-1:0] wr_gnt [num_banks];
    logic [num_ports-1:0] rd_gnt [num_banks];

    logic                 wr_en    [num_banks];
    entry_t               wr_entry [num_banks];
    logic [bit_width-1:0] wr_data  [num_banks];

    logic [bit_width-1:0] mem [num_banks][num_bank_entries];
    logic [num_ports-1:0] rd_acc;

    always_comb begin
        for (int b = 0; b < num_banks; b++) begin
            wr_req[b] = '0;
            rd_req[b] = '0;
        end
        for (int p = 0; p < num_ports; p++) begin
            for (int b = 0; b < num_banks; b++) begin
                if (req_valid[p] && bank_of(req_addr[p]) == bank_t'(b)) begin
                    if (req_we[p]) begin
                        wr_req[b][p] = 1'b1;
                    end else begin
                        rd_req[b][p] = 1'b1;
                    end
                end
            end
        end
    end

    for (genvar gb = 0; gb < num_banks; gb++) begin : g_bank_arb
        rr_arbiter #(.num_req(num_ports)) u_wr_arb (
            .clk   (clk),
            .rst_n (rst_n),
            .req   (wr_req[gb]),
            .grant (wr_gnt[gb])
        );
        rr_arbiter #(.num_req(num_ports)) u_rd_arb (
            .clk   (clk),
            .rst_n (rst_n),
            .req   (rd_req[gb]),
            .grant (rd_gnt[gb])
        );
    end

    // A port targets exactly one bank, so OR-ing all grants yields its ready
    always_comb begin
        req_ready = '0;
        for (int b = 0; b < num_banks; b++) begin
            req_ready = req_ready | wr_gnt[b] | rd_gnt[b];
        end
    end

    always_comb begin
        for (int b = 0; b < num_banks; b++) begin
            wr_en[b]    = 1'b0;
            wr_entry[b] = '0;
            wr_data[b]  = '0;
            for (int p = 0; p < num_ports; p++) begin
                if (wr_gnt[b][p]) begin
                    wr_en[b]    = 1'b1;
                    wr_entry[b] = entry_of(req_addr[p]);
                    wr_data[b]  = req_wdata[p];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < num_banks; b++) begin
            if (wr_en[b]) begin
                mem[b][wr_entry[b]] <= wr_data[b];
            end
        end
    end

    assign rd_acc = req_valid & ~req_we & req_ready;

    // Reads sample the array before this edge's writes, giving read-before-write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= '0;
            for (int p = 0; p < num_ports; p++) begin
                rsp_rdata[p] <= '0;
            end
        end else begin
            rsp_valid <= rd_acc;
            for (int p = 0; p < num_ports; p++) begin
                if (rd_acc[p]) begin
                    rsp_rdata[p] <= mem[bank_of(req_addr[p])][entry_of(req_addr[p])];
                end
            end
        end
    end

endmodule

// File: tb/tb_memory_mb_arb.sv
// Self-checking bench for memory_mb_arb: hand-written vector table for the corner
// cases plus randomized traffic compared against a flat-memory reference model.
module tb_memory_mb_arb;

    localparam int NP    = 2;
    localparam int NB    = 4;
    localparam int WORDS = 32;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_we;
    logic [4:0]  req_addr  [NP];
    logic [31:0] req_wdata [NP];
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata [NP];

    int n_checks;
    int n_errors;

    int          wr_ptr [NB];
    int          rd_ptr [NB];
    logic [31:0] mem_m [WORDS];
    bit          mem_known [WORDS];
    logic [1:0]  exp_valid;
    logic [31:0] exp_rdata [NP];
    bit          exp_known [NP];

    typedef struct {
        string       name;
        logic [1:0]  valid;
        logic [1:0]  we;
        logic [4:0]  addr0;
        logic [4:0]  addr1;
        logic [31:0] data0;
        logic [31:0] data1;
        logic [1:0]  exp_ready;
        int          rsp_port;
        logic [31:0] rsp_data;
    } vec_t;

    vec_t vecs [$];

    memory_mb_arb dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] v, input logic [1:0] we,
                                 input logic [4:0] a0, input logic [4:0] a1,
                                 input logic [31:0] d0, input logic [31:0] d1);
        @(negedge clk);
        req_valid    = v;
        req_we       = we;
        req_addr[0]  = a0;
        req_addr[1]  = a1;
        req_wdata[0] = d0;
        req_wdata[1] = d1;
        #1;
    endtask

    // Reference arbitration: among matching ports pick the one closest after the pointer
    function automatic int winner(input int b, input bit is_wr);
        int ptr;
        int best;
        int bestd;
        int d;
        ptr   = is_wr ? wr_ptr[b] : rd_ptr[b];
        best  = -1;
        bestd = NP;
        for (int p = 0; p < NP; p++) begin
            if (req_valid[p] && (req_we[p] == is_wr) && (int'(req_addr[p]) % NB == b)) begin
                d = (p - ptr + NP) % NP;
                if (d < bestd) begin
                    bestd = d;
                    best  = p;
                end
            end
        end
        return best;
    endfunction

    function automatic logic [1:0] model_ready();
        logic [1:0] r;
        int w;
        r = '0;
        for (int b = 0; b < NB; b++) begin
            w = winner(b, 1'b1);
            if (w >= 0) r[w] = 1'b1;
            w = winner(b, 1'b0);
            if (w >= 0) r[w] = 1'b1;
        end
        return r;
    endfunction

    task automatic modelEdge();
        int wwin [NB];
        int rwin [NB];
        int p;
        for (int b = 0; b < NB; b++) begin
            wwin[b] = winner(b, 1'b1);
            rwin[b] = winner(b, 1'b0);
        end
        exp_valid = '0;
        for (int b = 0; b < NB; b++) begin
            if (rwin[b] >= 0) begin
                p = rwin[b];
                exp_valid[p] = 1'b1;
                exp_rdata[p] = mem_m[req_addr[p]];
                exp_known[p] = mem_known[req_addr[p]];
                rd_ptr[b]    = (p + 1) % NP;
            end
        end
        for (int b = 0; b < NB; b++) begin
            if (wwin[b] >= 0) begin
                p = wwin[b];
                mem_m[req_addr[p]]     = req_wdata[p];
                mem_known[req_addr[p]] = 1'b1;
                wr_ptr[b]              = (p + 1) % NP;
            end
        end
    endtask

    task automatic modelReset();
        for (int b = 0; b < NB; b++) begin
            wr_ptr[b] = 0;
            rd_ptr[b] = 0;
        end
        exp_valid = '0;
        for (int p = 0; p < NP; p++) begin
            exp_rdata[p] = '0;
            exp_known[p] = 1'b1;
        end
    endtask

    task automatic checkResponses(input string tag);
        for (int p = 0; p < NP; p++) begin
            checkOutput($sformatf("%s rsp_valid[%0d]", tag, p), 32'(rsp_valid[p]), 32'(exp_valid[p]));
            if (exp_known[p]) begin
                checkOutput($sformatf("%s rsp_rdata[%0d]", tag, p), rsp_rdata[p], exp_rdata[p]);
            end
        end
    endtask

    task automatic stepCycle(input string tag, input logic [1:0] exp_ready);
        checkOutput({tag, " req_ready"}, 32'(req_ready), 32'(exp_ready));
        modelEdge();
        @(posedge clk);
        #1;
        checkResponses(tag);
    endtask

    task automatic doReset(input string tag);
        @(negedge clk);
        req_valid = '0;
        req_we    = '0;
        rst_n     = 1'b0;
        modelReset();
        #1;
        checkOutput({tag, " req_ready"}, 32'(req_ready), 32'h0);
        checkResponses(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b1;
        req_valid = '0;
        req_we    = '0;
        for (int p = 0; p < NP; p++) begin
            req_addr[p]  = '0;
            req_wdata[p] = '0;
        end
        for (int i = 0; i < WORDS; i++) begin
            mem_m[i]     = '0;
            mem_known[i] = 1'b0;
        end
        modelReset();

        doReset("reset");

        applyStimulus(2'b01, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        stepCycle("first_read", 2'b01);

        for (int a = 0; a < WORDS; a++) begin
            applyStimulus(2'b01, 2'b01, 5'(a), 5'd0, 32'(a), 32'h0);
            stepCycle($sformatf("fill[%0d]", a), 2'b01);
        end
        for (int a = 0; a < WORDS; a++) begin
            applyStimulus(2'b01, 2'b00, 5'(a), 5'd0, 32'h0, 32'h0);
            stepCycle($sformatf("readback[%0d]", a), 2'b01);
            checkOutput($sformatf("readback[%0d] data", a), rsp_rdata[0], 32'(a));
        end

        doReset("reset2");

        vecs.push_back('{"wr_conflict_a", 2'b11, 2'b11, 5'd1, 5'd5, 32'h11, 32'h55, 2'b01, -1, 32'h0});
        vecs.push_back('{"wr_conflict_b", 2'b11, 2'b11, 5'd1, 5'd5, 32'h11, 32'h55, 2'b10, -1, 32'h0});
        vecs.push_back('{"rd_alt_0", 2'b11, 2'b00, 5'd1, 5'd5, 32'h0, 32'h0, 2'b01, 0, 32'h11});
        vecs.push_back('{"rd_alt_1", 2'b11, 2'b00, 5'd1, 5'd5, 32'h0, 32'h0, 2'b10, 1, 32'h55});
        vecs.push_back('{"rd_alt_2", 2'b11, 2'b00, 5'd1, 5'd5, 32'h0, 32'h0, 2'b01, 0, 32'h11});
        vecs.push_back('{"rd_alt_3", 2'b11, 2'b00, 5'd1, 5'd5, 32'h0, 32'h0, 2'b10, 1, 32'h55});
        vecs.push_back('{"diff_bank", 2'b11, 2'b10, 5'd2, 5'd3, 32'h0, 32'h33, 2'b11, 0, 32'h2});
        vecs.push_back('{"same_bank_rw", 2'b11, 2'b10, 5'd4, 5'd0, 32'h0, 32'h100, 2'b11, 0, 32'h4});
        vecs.push_back('{"read_before_write", 2'b11, 2'b01, 5'd6, 5'd6, 32'hAA, 32'h0, 2'b11, 1, 32'h6});
        vecs.push_back('{"read_after_write", 2'b01, 2'b00, 5'd6, 5'd0, 32'h0, 32'h0, 2'b01, 0, 32'hAA});
        vecs.push_back('{"idle", 2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, -1, 32'h0});

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].valid, vecs[i].we, vecs[i].addr0, vecs[i].addr1,
                          vecs[i].data0, vecs[i].data1);
            stepCycle(vecs[i].name, vecs[i].exp_ready);
            if (vecs[i].rsp_port >= 0) begin
                checkOutput({vecs[i].name, " rsp_data"}, rsp_rdata[vecs[i].rsp_port], vecs[i].rsp_data);
            end
        end

        // Reset lands between accept and capture edge: that read must vanish
        applyStimulus(2'b01, 2'b00, 5'd7, 5'd0, 32'h0, 32'h0);
        checkOutput("async_accept req_ready", 32'(req_ready), 32'h1);
        #2;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkResponses("async_in_reset");
        @(posedge clk);
        #1;
        checkResponses("async_edge_in_reset");
        @(negedge clk);
        req_valid = '0;
        rst_n     = 1'b1;
        @(posedge clk);
        #1;
        checkResponses("async_after_release");

        applyStimulus(2'b01, 2'b00, 5'd7, 5'd0, 32'h0, 32'h0);
        stepCycle("read7_pre_drop", 2'b01);
        #1;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkResponses("async_drop");
        @(negedge clk);
        req_valid = '0;
        rst_n     = 1'b1;

        applyStimulus(2'b01, 2'b00, 5'd7, 5'd0, 32'h0, 32'h0);
        stepCycle("read7_post_reset", 2'b01);
        checkOutput("read7_post_reset data", rsp_rdata[0], 32'h7);

        for (int c = 0; c < 400; c++) begin
            applyStimulus(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                          5'($urandom_range(0, WORDS - 1)), 5'($urandom_range(0, WORDS - 1)),
                          $urandom, $urandom);
            stepCycle($sformatf("rand[%0d]", c), model_ready());
        end

        @(negedge clk);
        req_valid = '0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
